// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared constants, FSM state type and PC legality check for the fetch controller
//   ROM_DEPTH : number of valid instruction words in the ROM
//   ADDR_W    : ROM word-address width
//   RESET_PC  : PC loaded on reset
//   state_e   : fetch FSM states
//   pc_legal  : word aligned, inside the ROM, no stray upper bits
package inst_fetch_pkg;
    localparam int          ROM_DEPTH = 21;
    localparam int          ADDR_W    = 5;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_e;

    function automatic logic pc_legal(input logic [31:0] pc);
        return (pc[1:0] == 2'b00)
            && ({1'b0, pc[ADDR_W+1:2]} < (ADDR_W+1)'(ROM_DEPTH))
            && (pc[31:ADDR_W+2] == '0);
    endfunction
endpackage

// File: rtl/inst_fetch_ctrl_rom_port_arb.sv
// rom_port_arb: shares the single ROM read port between fetch and a debug reader
//   clk, reset    : clock, synchronous active-high reset
//   fetch_fire_i  : fetch owns the port this cycle
//   pc_idx_i      : fetch word address
//   dbg_req_i     : debug request level, held until granted
//   dbg_addr_i    : debug word address
//   rom_inst_i    : ROM data, same cycle
//   dbg_force_o   : debug waited too long, fetch must yield this cycle
//   rom_addr_o    : ROM word address
//   dbg_gnt_o     : port given to debug this cycle
//   dbg_rvalid_o  : dbg_data_o valid (one cycle after grant)
//   dbg_data_o    : registered debug read data
module rom_port_arb
    import inst_fetch_pkg::*;
#(
    parameter int DBG_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_fire_i,
    input  logic [ADDR_W-1:0] pc_idx_i,
    input  logic              dbg_req_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [31:0]       rom_inst_i,
    output logic              dbg_force_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [31:0]       dbg_data_o
);
    localparam int CW = $clog2(DBG_MAX_WAIT + 1);

    logic [CW-1:0] wait_q, wait_d;
    logic          dbg_rvalid_q, dbg_rvalid_d;
    logic [31:0]   dbg_data_q, dbg_data_d;

    // The force is gated by the request so an idle counter never steals a fetch slot.
    assign dbg_force_o  = dbg_req_i && (wait_q == CW'(DBG_MAX_WAIT - 1));
    assign dbg_gnt_o    = dbg_req_i && !fetch_fire_i;
    assign rom_addr_o   = dbg_gnt_o ? dbg_addr_i : pc_idx_i;
    assign dbg_rvalid_o = dbg_rvalid_q;
    assign dbg_data_o   = dbg_data_q;

    always_comb begin
        wait_d       = (dbg_gnt_o || !dbg_req_i) ? '0 : wait_q + 1'b1;
        dbg_rvalid_d = dbg_gnt_o;
        dbg_data_d   = dbg_gnt_o ? rom_inst_i : dbg_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q       <= '0;
            dbg_rvalid_q <= 1'b0;
            dbg_data_q   <= '0;
        end else begin
            wait_q       <= wait_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_data_q   <= dbg_data_d;
        end
    end
endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: owns the PC, fetches from the async ROM into a one-entry valid/ready register
//   clk, reset          : clock, synchronous active-high reset
//   rom_addr / rom_inst : ROM word address out, instruction in (same cycle)
//   id_valid/id_ready   : handshake of the registered instruction to decode
//   id_inst / id_pc     : registered instruction and its byte PC
//   br_valid/br_target  : redirect request and byte target
//   halt                : stop issuing fetches while high
//   dbg_req/dbg_addr    : debug read request and word address
//   dbg_gnt/dbg_rvalid/dbg_data : debug grant, read-data valid, read data
//   fault / fault_pc    : sticky illegal-PC flag and the offending PC
module inst_fetch_ctrl
    import inst_fetch_pkg::*;
#(
    parameter int DBG_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_inst,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_inst,
    output logic [31:0]       id_pc,
    input  logic              br_valid,
    input  logic [31:0]       br_target,
    input  logic              halt,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_data,
    output logic              fault,
    output logic [31:0]       fault_pc
);
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;

    logic slot_free, legal, dbg_force, fetch_fire, redirect, fault_det;

    assign slot_free  = !id_valid_q || id_ready;
    assign legal      = pc_legal(pc_q);
    assign fetch_fire = (state_q == RUN) && !halt && !br_valid && slot_free && legal && !dbg_force;
    assign redirect   = br_valid && (state_q != FAULT);
    // Only a real fetch attempt can fault; an illegal redirect target sits in pc until then.
    assign fault_det  = (state_q == RUN) && !halt && !br_valid && slot_free && !legal;

    always_comb begin
        pc_d       = redirect ? br_target : fetch_fire ? pc_q + 32'd4 : pc_q;
        id_valid_d = redirect ? 1'b0 : fetch_fire ? 1'b1 : id_ready ? 1'b0 : id_valid_q;
        id_inst_d  = fetch_fire ? rom_inst : id_inst_q;
        id_pc_d    = fetch_fire ? pc_q : id_pc_q;
        fault_d    = fault_q || fault_det;
        fault_pc_d = fault_det ? pc_q : fault_pc_q;
        state_d    = (state_q == FAULT || fault_det) ? FAULT :
                     (state_q == RUN && halt)        ? HALT  :
                     (state_q == HALT && !halt)      ? RUN   : state_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            id_valid_q <= 1'b0;
            id_inst_q  <= '0;
            id_pc_q    <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_valid_q <= id_valid_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    rom_port_arb #(.DBG_MAX_WAIT(DBG_MAX_WAIT)) u_arb (
        .clk          (clk),
        .reset        (reset),
        .fetch_fire_i (fetch_fire),
        .pc_idx_i     (pc_q[ADDR_W+1:2]),
        .dbg_req_i    (dbg_req),
        .dbg_addr_i   (dbg_addr),
        .rom_inst_i   (rom_inst),
        .dbg_force_o  (dbg_force),
        .rom_addr_o   (rom_addr),
        .dbg_gnt_o    (dbg_gnt),
        .dbg_rvalid_o (dbg_rvalid),
        .dbg_data_o   (dbg_data)
    );

    assign id_valid = id_valid_q;
    assign id_inst  = id_inst_q;
    assign id_pc    = id_pc_q;
    assign fault    = fault_q;
    assign fault_pc = fault_pc_q;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed and randomized checks of inst_fetch_ctrl against a behavioural model
module tb_inst_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rom_addr;
    logic [31:0] rom_inst;
    logic        id_valid, id_ready;
    logic [31:0] id_inst, id_pc;
    logic        br_valid;
    logic [31:0] br_target;
    logic        halt, dbg_req;
    logic [4:0]  dbg_addr;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_data;
    logic        fault;
    logic [31:0] fault_pc;

    logic [31:0] rom [32];
    assign rom_inst = rom[rom_addr];

    always #5 clk = ~clk;

    inst_fetch_ctrl dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
        .br_valid(br_valid), .br_target(br_target), .halt(halt),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_data(dbg_data),
        .fault(fault), .fault_pc(fault_pc)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Model state: fetch PC, halted/faulted flags, output register, debug side.
    logic [31:0] m_pc, m_inst, m_ipc, m_fpc, m_rd;
    bit          m_hlt, m_flt, m_v, m_rv;
    int          m_wait;
    bit          last_gnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Legal: word aligned and below the 21-word ROM (84 bytes).
    function automatic bit legal(input logic [31:0] p);
        return p[1:0] == 2'b00 && p < 32'd84;
    endfunction

    task automatic m_reset();
        m_pc = 0; m_inst = 0; m_ipc = 0; m_fpc = 0; m_rd = 0;
        m_hlt = 0; m_flt = 0; m_v = 0; m_rv = 0; m_wait = 0;
    endtask

    task automatic chk_regs();
        chk("id_valid", 32'(id_valid), 32'(m_v));
        chk("id_inst", id_inst, m_inst);
        chk("id_pc", id_pc, m_ipc);
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'(m_rv));
        chk("dbg_data", dbg_data, m_rd);
        chk("fault", 32'(fault), 32'(m_flt));
        chk("fault_pc", fault_pc, m_fpc);
    endtask

    // Entered at posedge+1 with inputs already driven; leaves at the next posedge+1.
    task automatic cyc();
        bit run, free, frc, fire, gnt, fdet;
        logic [4:0] a;
        #1;
        run  = !m_flt && !m_hlt;
        free = !m_v || id_ready;
        frc  = dbg_req && m_wait == 7;
        fire = run && !halt && !br_valid && free && legal(m_pc) && !frc;
        gnt  = dbg_req && !fire;
        fdet = run && !halt && !br_valid && free && !legal(m_pc);
        a    = gnt ? dbg_addr : m_pc[6:2];
        chk("rom_addr", 32'(rom_addr), 32'(a));
        chk("dbg_gnt", 32'(dbg_gnt), 32'(gnt));
        last_gnt = gnt;
        if (reset) m_reset();
        else begin
            if (fdet) begin m_flt = 1; m_fpc = m_pc; end
            else if (run && halt) m_hlt = 1;
            else if (m_hlt && !halt) m_hlt = 0;
            if (br_valid && !(m_flt && !fdet)) begin m_pc = br_target; m_v = 0; end
            else if (fire) begin m_inst = rom[m_pc[6:2]]; m_ipc = m_pc; m_v = 1; m_pc = m_pc + 4; end
            else if (id_ready) m_v = 0;
            m_rv = gnt;
            if (gnt) m_rd = rom[dbg_addr];
            m_wait = (gnt || !dbg_req) ? 0 : m_wait + 1;
        end
        @(posedge clk); #1;
        chk_regs();
    endtask

    task automatic idle();
        reset = 0; id_ready = 1; br_valid = 0; br_target = 0; halt = 0; dbg_req = 0; dbg_addr = 0;
    endtask

    task automatic do_reset();
        reset = 1; cyc(); reset = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = (i < 21) ? (32'h2000_0000 | 32'(i)) : (32'hBAD0_0000 | 32'(i));
        rom[0] = 32'h2401_0001; rom[1] = 32'h0001_1100; rom[2] = 32'h0041_1821;
        rom[3] = 32'h0002_2082; rom[13] = 32'h8C2A_0013; rom[18] = 32'h3C0C_000C;
        idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        chk_regs();
        do_reset();
        // Full-rate fetch straight out of reset.
        cyc(); chk("seq0_pc", id_pc, 32'h0); chk("seq0_inst", id_inst, 32'h2401_0001);
        cyc(); chk("seq1_inst", id_inst, 32'h0001_1100);
        cyc(); chk("seq2_pc", id_pc, 32'h8); chk("seq2_inst", id_inst, 32'h0041_1821);
        // Back-pressure holds the entry.
        id_ready = 0;
        repeat (3) cyc();
        chk("stall_inst", id_inst, 32'h0041_1821);
        id_ready = 1;
        cyc(); chk("release_inst", id_inst, 32'h0002_2082);
        for (int i = 0; i < 20 && !(id_valid && id_pc == 32'h2C); i++) cyc();
        chk("reach_2c", id_pc, 32'h2C);
        br_valid = 1; br_target = 32'h34;
        cyc(); chk("flush", 32'(id_valid), 32'h0);
        br_valid = 0;
        cyc(); chk("br_pc", id_pc, 32'h34); chk("br_inst", id_inst, 32'h8C2A_0013);
        // Illegal redirect targets: one past the ROM, then misaligned.
        br_valid = 1; br_target = 32'h54; cyc(); br_valid = 0;
        cyc(); chk("fault54", 32'(fault), 32'h1); chk("fault_pc54", fault_pc, 32'h54);
        repeat (4) cyc();
        chk("fault_quiet", 32'(id_valid), 32'h0);
        do_reset();
        br_valid = 1; br_target = 32'h06; cyc(); br_valid = 0;
        cyc(); chk("fault_pc06", fault_pc, 32'h06);
        do_reset();
        // Debug starved by full-rate fetch is forced through on its 8th cycle.
        dbg_req = 1; dbg_addr = 5'd18;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("dbg_gnt_cycle", 32'(last_gnt), 32'(i == 7));
        end
        dbg_req = 0;
        chk("dbg_data18", dbg_data, 32'h3C0C_000C);
        chk("dbg_rvalid18", 32'(dbg_rvalid), 32'h1);
        // Reset wins over everything in flight.
        reset = 1; br_valid = 1; br_target = 32'h10; dbg_req = 1;
        cyc(); chk("rst_valid", 32'(id_valid), 32'h0); chk("rst_rv", 32'(dbg_rvalid), 32'h0);
        idle();
        cyc(); chk("restart_inst", id_inst, 32'h2401_0001);
        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if (last_gnt) dbg_req = 0;
            reset     = ($urandom_range(0, 39) == 0);
            id_ready  = ($urandom_range(0, 3) != 0);
            br_valid  = ($urandom_range(0, 7) == 0);
            br_target = ($urandom_range(0, 9) == 0) ? $urandom : (32'($urandom_range(0, 22)) << 2);
            if ($urandom_range(0, 19) == 0) halt = !halt;
            if (!dbg_req && $urandom_range(0, 5) == 0) begin
                dbg_req  = 1;
                dbg_addr = 5'($urandom_range(0, 31));
            end
            cyc();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
